// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Logic, arithmetic, compare and illegal codes complete in one cycle.
// Shifts with a nonzero amount step one bit per cycle through a working register.
// Flags are registered with the result and are meaningful only while out_valid is high.
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         alu_ctl,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               ovf,
    output logic               illegal
);

    localparam logic [3:0] CTL_ADD = 4'b0000;
    localparam logic [3:0] CTL_SUB = 4'b0001;
    localparam logic [3:0] CTL_AND = 4'b0010;
    localparam logic [3:0] CTL_OR  = 4'b0011;
    localparam logic [3:0] CTL_SLL = 4'b0100;
    localparam logic [3:0] CTL_SRL = 4'b0101;
    localparam logic [3:0] CTL_SRA = 4'b0110;
    localparam logic [3:0] CTL_NOR = 4'b0111;
    localparam logic [3:0] CTL_SLT = 4'b1000;

    localparam int MSB = WIDTH - 1;
    localparam logic [WIDTH-1:0]   ONE_W = WIDTH'(1);
    localparam logic [SHAMT_W-1:0] ONE_S = SHAMT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ovf;
    logic               r_illegal;

    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic [3:0]         r_ctl;

    logic               w_accept;
    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;
    logic               w_illegal;
    logic               w_is_shift;
    logic [WIDTH-1:0]   w_work_next;

    assign w_accept = in_valid & r_in_ready;

    // Single-cycle result and flags for the op presented at the inputs.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so codes outside the case never infer a latch.
        w_b_eff    = (alu_ctl == CTL_SUB) ? (~op_b + ONE_W) : op_b;
        w_sum      = op_a + w_b_eff;
        w_res      = '0;
        w_ovf      = 1'b0;
        w_illegal  = 1'b0;
        w_is_shift = 1'b0;
        case (alu_ctl)
            CTL_ADD, CTL_SUB: begin
                w_res = w_sum;
                w_ovf = (op_a[MSB] == w_b_eff[MSB]) & (w_sum[MSB] != op_a[MSB]);
            end
            CTL_AND: w_res = op_a & op_b;
            CTL_OR:  w_res = op_a | op_b;
            CTL_NOR: w_res = ~(op_a | op_b);
            CTL_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            CTL_SLL, CTL_SRL, CTL_SRA: begin
                // A zero shift amount completes immediately with op_b unchanged.
                w_res      = op_b;
                w_is_shift = 1'b1;
            end
            // Decoder don't-cares land here and resolve to a defined illegal result.
            default: w_illegal = 1'b1;
        endcase
    end

    // One-bit step of the working register for the latched shift kind.
    always_comb begin
        w_work_next = r_work;
        case (r_ctl)
            CTL_SLL: w_work_next = {r_work[MSB-1:0], 1'b0};
            CTL_SRL: w_work_next = {1'b0, r_work[MSB:1]};
            default: w_work_next = {r_work[MSB], r_work[MSB:1]};
        endcase
    end

    // Working register and remaining-step counter: loaded on accept, stepped while shifting.
    // NOTE: these datapath registers carry no reset; the FSM never reads them outside SHIFT.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_work <= op_b;
            r_cnt  <= shamt;
            r_ctl  <= alu_ctl;
        end else if (r_state == ST_SHIFT) begin
            // NOTE: non-blocking assignments keep every register update on the same clock edge.
            r_work <= w_work_next;
            r_cnt  <= r_cnt - ONE_S;
        end
    end

    // Control FSM with registered handshake outputs, result and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (flush) begin
            // Abort whatever is in flight; result keeps its previous value.
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        if (w_is_shift && (shamt != '0)) begin
                            r_state <= ST_SHIFT;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_res;
                            r_zero      <= (w_res == '0);
                            r_ovf       <= w_ovf;
                            r_illegal   <= w_illegal;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt == ONE_S) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_work_next;
                        r_zero      <= (w_work_next == '0);
                        r_ovf       <= 1'b0;
                        r_illegal   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_in_ready  <= 1'b1;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign zero      = r_zero;
    assign ovf       = r_ovf;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vectors, an arithmetic reference model of each op,
// and a per-cycle compare of handshake outputs and results against that model.
module tb_alu_exec_unit;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] AND = 4'b0010;
    localparam logic [3:0] OR  = 4'b0011;
    localparam logic [3:0] SLL = 4'b0100;
    localparam logic [3:0] SRL = 4'b0101;
    localparam logic [3:0] SRA = 4'b0110;
    localparam logic [3:0] NOR = 4'b0111;
    localparam logic [3:0] SLT = 4'b1000;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  alu_ctl   = 4'd0;
    logic [31:0] op_a      = 32'd0;
    logic [31:0] op_b      = 32'd0;
    logic [4:0]  shamt     = 5'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        illegal;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctl   (alu_ctl),
        .op_a      (op_a),
        .op_b      (op_b),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Reference state: one op at most is outstanding between accept and consumption.
    bit          pending = 1'b0;
    int          acc_cyc = 0;
    int          m_lat   = 1;
    logic [31:0] m_res   = 32'd0;
    bit          m_zero  = 1'b0;
    bit          m_ovf   = 1'b0;
    bit          m_ill   = 1'b0;
    bit          exp_ov;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s timed out (t=%0t)", name, $time);
    endtask

    // What the op must produce, computed straight from the operation's definition.
    function automatic void model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sh, output logic [31:0] r, output bit z,
                                  output bit ov, output bit il, output int lat);
        logic [31:0]        bn;
        logic signed [31:0] sb;
        r   = 32'd0;
        ov  = 1'b0;
        il  = 1'b0;
        lat = 1;
        sb  = b;
        case (c)
            ADD: begin
                r  = a + b;
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            SUB: begin
                bn = -b;
                r  = a - b;
                ov = (a[31] == bn[31]) && (r[31] != a[31]);
            end
            AND: r = a & b;
            OR:  r = a | b;
            NOR: r = ~(a | b);
            SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            SLL: begin r = b << sh;  lat = int'(sh) + 1; end
            SRL: begin r = b >> sh;  lat = int'(sh) + 1; end
            SRA: begin r = sb >>> sh; lat = int'(sh) + 1; end
            default: il = 1'b1;
        endcase
        z = (r == 32'd0);
    endfunction

    // Cycle count and consumption of the outstanding result on a handshake edge.
    always @(posedge clk) begin
        cyc++;
        if (!reset && !flush && out_valid && out_ready) pending = 1'b0;
    end

    // Per-cycle compare of the DUT against the reference, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            exp_ov = pending && ((cyc - acc_cyc) >= (m_lat - 1));
            check("in_ready", in_ready, !pending);
            check("out_valid", out_valid, exp_ov);
            if (out_valid && exp_ov) begin
                check("result", result, m_res);
                check("zero", zero, m_zero);
                check("ovf", ovf, m_ovf);
                check("illegal", illegal, m_ill);
            end
        end
    end

    // Present one op at a negedge, let it be accepted, then scramble the inputs.
    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input bit fl);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_timeout("issue_wait_ready");
        alu_ctl  = c;
        op_a     = a;
        op_b     = b;
        shamt    = sh;
        in_valid = 1'b1;
        flush    = fl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        shamt    = 5'($urandom);
        alu_ctl  = 4'($urandom);
        if (fl) begin
            pending = 1'b0;
        end else begin
            model(c, a, b, sh, m_res, m_zero, m_ovf, m_ill, m_lat);
            pending = 1'b1;
            acc_cyc = cyc;
        end
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail_timeout("wait_out_valid");
    endtask

    // Issue, then stop at the first cycle the result is visible.
    task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh);
        issue(c, a, b, sh, 1'b0);
        wait_valid(40);
    endtask

    typedef struct {
        logic [3:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          n;
        logic [31:0] cap;

        vecs[0] = '{AND, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0};
        vecs[1] = '{OR,  32'hF000_0000, 32'h0000_000F, 5'd0};
        vecs[2] = '{NOR, 32'h0000_0000, 32'h0000_0000, 5'd0};
        vecs[3] = '{SUB, 32'h8000_0000, 32'h0000_0001, 5'd0};
        vecs[4] = '{ADD, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0};
        vecs[5] = '{SLT, 32'h0000_0005, 32'h0000_0003, 5'd0};
        vecs[6] = '{SRL, 32'hF000_0000, 32'h0000_0000, 5'd0};
        vecs[7] = '{SLL, 32'h0000_0000, 32'h0000_0013, 5'd3};
        vecs[8] = '{SRA, 32'h0000_0000, 32'h7000_0000, 5'd4};
        vecs[9] = '{SRL, 32'h0000_0000, 32'h8000_00F0, 5'd4};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {zero, ovf, illegal}, 0);

        // Signed overflow on add, one-cycle latency.
        run_op(ADD, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0);
        check("t1_result", result, 32'h8000_0000);
        check("t1_ovf", ovf, 1);
        check("t1_zero", zero, 0);
        @(negedge clk);

        // Zero result from sub; signed compare of -1 against 1.
        run_op(SUB, 32'd5, 32'd5, 5'd0);
        check("t2_sub_result", result, 0);
        check("t2_sub_zero", zero, 1);
        check("t2_sub_ovf", ovf, 0);
        @(negedge clk);
        run_op(SLT, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0);
        check("t2_slt_result", result, 32'd1);
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].c, vecs[i].a, vecs[i].b, vecs[i].sh);
            @(negedge clk);
        end

        // Longest shift: busy for 32 cycles including the DONE cycle.
        issue(SRA, 32'd0, 32'h8000_0000, 5'd31, 1'b0);
        n   = 0;
        cap = 32'd0;
        while (!in_ready && n < 100) begin
            if (out_valid) cap = result;
            n++;
            @(negedge clk);
        end
        check("t3_busy_cycles", n, 32);
        check("t3_sra_result", cap, 32'hFFFF_FFFF);
        run_op(SRL, 32'd0, 32'h8000_0000, 5'd31);
        check("t3_srl_result", result, 32'h0000_0001);
        @(negedge clk);

        // Zero-amount shift completes in one cycle; result held while the consumer stalls.
        out_ready = 1'b0;
        issue(SLL, 32'd0, 32'h0000_1234, 5'd0, 1'b0);
        check("t4_latency", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_result", result, 32'h0000_1234);
            check("t4_hold_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);

        // Flush in the third shift cycle abandons the op.
        issue(SLL, 32'd0, 32'h0000_0001, 5'd10, 1'b0);
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush   = 1'b0;
        pending = 1'b0;
        @(negedge clk);
        check("t5_flush_in_ready", in_ready, 1);
        check("t5_flush_out_valid", out_valid, 0);
        repeat (12) @(negedge clk);

        // Reset while a result waits in DONE.
        out_ready = 1'b0;
        issue(ADD, 32'd3, 32'd4, 5'd0, 1'b0);
        check("t5_done_before_reset", result, 32'd7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        pending   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t5_rst_in_ready", in_ready, 1);
        check("t5_rst_out_valid", out_valid, 0);
        check("t5_rst_result", result, 0);
        check("t5_rst_flags", {zero, ovf, illegal}, 0);

        // Unlisted control codes.
        run_op(4'b1011, 32'd12, 32'd34, 5'd0);
        check("t6_ill_result", result, 0);
        check("t6_ill_flag", illegal, 1);
        check("t6_ill_zero", zero, 1);
        @(negedge clk);
        run_op(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        check("t6_ill_1111", illegal, 1);
        @(negedge clk);

        // in_valid pulsed while busy must not start a second op.
        issue(SRA, 32'd0, 32'hF000_0000, 5'd8, 1'b0);
        alu_ctl  = ADD;
        op_a     = 32'd1;
        op_b     = 32'd2;
        in_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(20);
        check("t6_busy_result", result, 32'hFFF0_0000);
        @(negedge clk);
        repeat (4) @(negedge clk);

        // Flush on the accept edge drops the op.
        issue(ADD, 32'd1, 32'd2, 5'd0, 1'b1);
        check("flush_accept_out_valid", out_valid, 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

endmodule
